// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared types and constants for the instruction-fetch front end
package ifetch_unit_pkg;
  typedef logic u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;
  localparam u64 INSTR_BYTES = 64'd4;
  typedef struct packed {
    u1  valid;
    u64 pc;
    u32 raw_instr;
  } fetch_data_t;
  typedef enum logic [1:0] {FETCH, FULL, DROP} ifetch_state_t;
  function automatic u64 align_pc(input u64 a);
    return {a[63:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding ibus fetcher feeding the F/D register from a one-entry buffer
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter u64 RESET_PC = 64'h0000_0000_8000_0000,
  parameter int INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ireq_valid,
  output logic [63:0]        ireq_addr,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_pc,
  input  logic               hold,
  output fetch_data_t        dataF,
  output logic               stallI
);
  ifetch_state_t state, state_n;
  u64 pc, pc_n, req_pc, req_n, tgt;
  fetch_data_t fbuf, buf_n;
  always_comb begin
    tgt = align_pc(redirect_pc);
    state_n = state;
    pc_n = redirect_valid ? tgt : pc;
    req_n = req_pc;
    buf_n = fbuf;
    if (redirect_valid) buf_n.valid = 1'b0;
    case (state)
      FETCH:
        if (iresp_data_ok) begin
          if (redirect_valid) req_n = tgt;
          else begin
            buf_n = '{valid: 1'b1, pc: req_pc, raw_instr: u32'(iresp_data)};
            pc_n = req_pc + INSTR_BYTES;
            state_n = FULL;
          end
        end else if (redirect_valid) state_n = DROP;
      FULL:
        if (redirect_valid || !hold) begin
          buf_n.valid = 1'b0;
          req_n = redirect_valid ? tgt : pc;
          state_n = FETCH;
        end
      DROP:
        if (iresp_data_ok) begin
          req_n = redirect_valid ? tgt : pc;
          state_n = FETCH;
        end
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      req_pc <= RESET_PC;
      fbuf <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      req_pc <= req_n;
      fbuf <= buf_n;
    end
  assign ireq_valid = !reset && state != FULL;
  assign ireq_addr = req_pc;
  assign dataF = reset ? '0 : fbuf;
  assign stallI = !reset && !fbuf.valid;
endmodule
